// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/sequencing controller in front of the 32-bit ALU.
// One operation is in flight at a time. Its operands and opcode are held
// stable for a per-class number of cycles. After that the result, flags and
// HI/LO are captured and returned over a valid/ready response channel.
// Optional feature: define ALU_STICKY_OVF_EN to add a sticky overflow flag
// (ports ovf_sticky / ovf_clr).
module alu_issue_ctrl #(
    parameter int unsigned ALU_CYCLES = 1,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic [6:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic [3:0]  alu_flags,
`ifdef ALU_STICKY_OVF_EN
    output logic        ovf_sticky,
    input  logic        ovf_clr,
`endif
    output logic        busy
);

    // Opcode of the ALU default class; it yields result 0 while idle.
    localparam logic [6:0] OP_DFLT  = 7'b111_0000;
    localparam logic [6:0] OP_MULTU = 7'b000_0001;
    localparam logic [6:0] OP_MULT  = 7'b000_0010;

    // The counter is loaded with L-1 so that the capture edge is E0+L.
    localparam logic [7:0] ALU_LD = 8'(ALU_CYCLES - 1);
    localparam logic [7:0] MUL_LD = 8'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [6:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_result_q;
    logic [3:0]  rsp_flags_q;
    logic        rsp_err_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    logic        capture;
    logic        op_undef;
    logic        op_is_mul;

    // Hold-time selection for an incoming request, plus the capture/class decode of the held op.
    always_comb begin
        cnt_d     = ((req_op == OP_MULTU) || (req_op == OP_MULT)) ? MUL_LD : ALU_LD;
        capture   = (state_q == EXEC) && (cnt_q == 8'd0);
        op_undef  = (op_q[6:4] > 3'b011);
        op_is_mul = (op_q == OP_MULTU) || (op_q == OP_MULT);
    end

    // The ALU inputs come straight from the held registers, so they only move on accept/release edges.
    assign alu_op     = op_q;
    assign alu_in1    = a_q;
    assign alu_in2    = b_q;
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign hi_reg     = hi_q;
    assign lo_reg     = lo_q;
    assign busy       = busy_q;

    // Issue FSM with registered handshake outputs and response/HI/LO capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_DFLT;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        cnt_q       <= cnt_d;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        // Undefined classes still run for ALU_CYCLES but return a clean zero result.
                        rsp_result_q <= op_undef ? 32'd0 : alu_result;
                        rsp_flags_q  <= op_undef ? 4'd0 : alu_flags;
                        rsp_err_q    <= op_undef;
                        if (op_is_mul) begin
                            hi_q <= alu_hi;
                            lo_q <= alu_lo;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_q        <= OP_DFLT;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic ovf_sticky_q;

    // Sticky overflow flag: a set on a capture edge takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
        end else if (capture && alu_flags[2]) begin
            ovf_sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. A behavioural ALU stub sits on the alu_* side.
// Directed and random operations are checked against a transaction-level model.
module tb_alu_issue_ctrl;

    localparam int unsigned ALU_CYC = 1;
    localparam int unsigned MUL_CYC = 4;

    localparam logic [6:0] OP_DFLT  = 7'b111_0000;
    localparam logic [6:0] OP_MULTU = 7'b000_0001;
    localparam logic [6:0] OP_MULT  = 7'b000_0010;
    localparam logic [6:0] OP_ADDI  = 7'b000_0100;
    localparam logic [6:0] OP_AND   = 7'b001_0000;
    localparam logic [6:0] OP_XOR   = 7'b001_0001;
    localparam logic [6:0] OP_OR    = 7'b001_0010;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  f;
    } alu_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [6:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_result;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic [3:0]  alu_flags;
    logic        busy;
`ifdef ALU_STICKY_OVF_EN
    logic        ovf_sticky;
    logic        ovf_clr;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    alu_issue_ctrl #(.ALU_CYCLES(ALU_CYC), .MUL_CYCLES(MUL_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .hi_reg(hi_reg), .lo_reg(lo_reg),
        .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_flags(alu_flags),
`ifdef ALU_STICKY_OVF_EN
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: flags {z, o, c, s}. Undefined classes return junk so forcing is visible.
    function automatic alu_t ref_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_t o;
        logic [63:0] p;
        logic [32:0] s;
        o    = '0;
        o.hi = ~a;
        o.lo = ~b;
        case (op)
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                o.hi = p[63:32]; o.lo = p[31:0]; o.r = p[31:0];
            end
            OP_MULT: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                o.hi = p[63:32]; o.lo = p[31:0]; o.r = p[31:0];
            end
            OP_ADDI: begin
                s = {1'b0, a} + {1'b0, b};
                o.r = s[31:0];
                o.f[1] = s[32];
                o.f[2] = (a[31] == b[31]) && (s[31] != a[31]);
            end
            OP_AND:  o.r = a & b;
            OP_XOR:  o.r = a ^ b;
            OP_OR:   o.r = a | b;
            OP_DFLT: begin o.r = 32'd0; o.hi = 32'd0; o.lo = 32'd0; end
            default: begin o.r = (a + b) ^ 32'h5A5A_5A5A; o.f[2] = 1'b1; o.f[1] = 1'b1; end
        endcase
        o.f[3] = (o.r == 32'd0);
        o.f[0] = o.r[31];
        return o;
    endfunction

    // Combinational ALU stub driven by the controller's held operands.
    always_comb begin
        alu_t t;
        t          = ref_alu(alu_op, alu_in1, alu_in2);
        alu_result = t.r;
        alu_hi     = t.hi;
        alu_lo     = t.lo;
        alu_flags  = t.f;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; entered and left at posedge+1. bp = cycles of rsp_ready backpressure.
    task automatic do_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
        alu_t e;
        logic undef;
        logic is_mul;
        logic [31:0] exp_res;
        logic [3:0]  exp_f;
        int L;
        int lat;
        int n;
        int unstable;
        int bad;
        e       = ref_alu(op, a, b);
        undef   = (op[6:4] > 3'b011);
        is_mul  = (op == OP_MULT) || (op == OP_MULTU);
        exp_res = undef ? 32'd0 : e.r;
        exp_f   = undef ? 4'd0 : e.f;
        L       = is_mul ? int'(MUL_CYC) : int'(ALU_CYC);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) chk("ready_wait", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 7'($urandom); req_a = $urandom; req_b = $urandom;
        lat = 0; unstable = 0;
        while (!rsp_valid && lat < 300) begin
            if (alu_op !== op || alu_in1 !== a || alu_in2 !== b || req_ready !== 1'b0 || busy !== 1'b1)
                unstable++;
            @(posedge clk); #1;
            lat++;
        end
        if (is_mul) begin exp_hi = e.hi; exp_lo = e.lo; end
        chk("latency", 64'(lat), 64'(L));
        chk("operands_stable", 64'(unstable), 64'(0));
        chk("result", 64'(rsp_result), 64'(exp_res));
        chk("flags", 64'(rsp_flags), 64'(exp_f));
        chk("err", 64'(rsp_err), 64'(undef));
        chk("hi", 64'(hi_reg), 64'(exp_hi));
        chk("lo", 64'(lo_reg), 64'(exp_lo));
        bad = 0;
        for (int i = 0; i < bp; i++) begin
            req_valid = 1'b1; req_op = 7'($urandom); req_a = $urandom; req_b = $urandom;
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_flags !== exp_f ||
                rsp_err !== undef || req_ready !== 1'b0 || alu_op !== op || alu_in1 !== a ||
                hi_reg !== exp_hi || lo_reg !== exp_lo)
                bad++;
        end
        if (bp > 0) chk("backpressure_hold", 64'(bad), 64'(0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'(0));
        chk("idle_ready", 64'({req_ready, busy}), 64'(2'b10));
        chk("idle_op", 64'(alu_op), 64'(OP_DFLT));
        req_valid = 1'b0;
    endtask

    initial begin
        int vbad;
        logic [6:0] oplist [6];
        logic [6:0] op;
        int r;
        oplist = '{OP_MULTU, OP_MULT, OP_ADDI, OP_XOR, OP_AND, OP_OR};
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = 7'd0; req_a = 32'd0; req_b = 32'd0;
`ifdef ALU_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hs", 64'({req_ready, rsp_valid, busy, rsp_err}), 64'(4'b1000));
        chk("rst_rsp", 64'({rsp_result, rsp_flags}), 64'(0));
        chk("rst_hilo", {hi_reg, lo_reg}, 64'(0));
        chk("rst_alu", 64'({alu_op, alu_in1, alu_in2}), 64'({OP_DFLT, 64'd0}));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_ADDI, 32'd5, 32'd7, 0);
        chk("addi_res", 64'(rsp_result), 64'(12));
        chk("addi_flags", 64'(rsp_flags), 64'(0));
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd4, 0);
        chk("mult_hilo", {hi_reg, lo_reg}, 64'hFFFF_FFFF_FFFF_FFF4);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
        chk("multu_hilo", {hi_reg, lo_reg}, 64'h0000_0001_FFFF_FFFE);
        do_op(OP_XOR, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 0);
        chk("xor_res", 64'({rsp_result, rsp_flags}), 64'({32'd0, 4'b1000}));
        chk("xor_hilo", {hi_reg, lo_reg}, 64'h0000_0001_FFFF_FFFE);
        do_op(OP_ADDI, 32'h7FFF_FFFF, 32'd1, 3);
        chk("ovf_res", 64'({rsp_result, rsp_flags}), 64'({32'h8000_0000, 4'b0101}));
`ifdef ALU_STICKY_OVF_EN
        chk("sticky_set", 64'(ovf_sticky), 64'(1));
        do_op(OP_AND, 32'd3, 32'd1, 0);
        chk("sticky_keep", 64'(ovf_sticky), 64'(1));
        ovf_clr = 1'b1; @(posedge clk); #1; ovf_clr = 1'b0;
        chk("sticky_clr", 64'(ovf_sticky), 64'(0));
`endif
        do_op(7'b101_0000, 32'h1234_5678, 32'h9ABC_DEF0, 2);
        chk("undef", 64'({rsp_err, rsp_result, rsp_flags}), 64'({1'b1, 36'd0}));

        // Reset two cycles into a multiply: no response, HI/LO cleared at once.
        req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd9; req_b = 32'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("midrst_hs", 64'({req_ready, rsp_valid, busy}), 64'(3'b100));
        chk("midrst_hilo", {hi_reg, lo_reg}, 64'(0));
        chk("midrst_op", 64'(alu_op), 64'(OP_DFLT));
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        vbad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) vbad++;
        end
        chk("midrst_no_rsp", 64'(vbad), 64'(0));

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 7);
            if (r < 6) op = oplist[r];
            else op = {3'($urandom_range(4, 7)), 4'($urandom)};
            do_op(op, (k % 16 == 0) ? 32'h7FFF_FFFF : $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
